hazard_fwd_unit: RTL and testbench

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit.sv | 118 +++++++++++
 tb/tb_hazard_fwd_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard detection and EX operand forwarding, with a single fixed-latency
// long-op unit tracked by a down-counter and saturating stall performance counters.
module hazard_fwd_unit #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int LO_LAT  = 4,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_lo_op,
  input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_memread,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_AW-1:0]         ex_mem_reg_rd,
  input  logic                      mem_wb_regwrite,
  input  logic [REG_AW-1:0]         mem_wb_reg_rd,
  output logic [2*NUM_SRC-1:0]      forward_sel,
  output logic                      stall,
  output logic                      lo_done,
  output logic                      lo_busy,
  output logic [CNT_W-1:0]          cnt_loaduse,
  output logic [CNT_W-1:0]          cnt_lostall
);

  localparam logic [3:0] LO_LAT_C = 4'(LO_LAT);

  logic              lo_busy_q, lo_busy_d;
  logic [3:0]        lo_cnt_q, lo_cnt_d;
  logic [REG_AW-1:0] lo_rd_q, lo_rd_d;
  logic [CNT_W-1:0]  cnt_lu_q, cnt_lu_d;
  logic [CNT_W-1:0]  cnt_ls_q, cnt_ls_d;
  logic              luh, lrh, lwh, lsh, accept;

  always_comb begin
    forward_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_mem_regwrite && (ex_mem_reg_rd != '0) &&
          (ex_mem_reg_rd == id_ex_rs[i*REG_AW +: REG_AW]))
        forward_sel[2*i +: 2] = 2'b10;
      else if (mem_wb_regwrite && (mem_wb_reg_rd != '0) &&
               (mem_wb_reg_rd == id_ex_rs[i*REG_AW +: REG_AW]))
        forward_sel[2*i +: 2] = 2'b01;
    end
  end

  // A slot only participates when it is actually read and is not x0.
  always_comb begin
    luh = 1'b0;
    lrh = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_valid && id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] != '0)) begin
        if (id_ex_memread && (id_ex_rd != '0) && (id_rs[i*REG_AW +: REG_AW] == id_ex_rd))
          luh = 1'b1;
        if (lo_busy_q && (lo_rd_q != '0) && (id_rs[i*REG_AW +: REG_AW] == lo_rd_q))
          lrh = 1'b1;
      end
    end
  end

  assign lo_done = lo_busy_q && (lo_cnt_q == 4'd1);
  assign lo_busy = lo_busy_q;
  assign lwh     = lo_busy_q && id_valid && id_regwrite && (id_rd != '0) && (id_rd == lo_rd_q);
  assign lsh     = lo_busy_q && !lo_done && id_valid && id_lo_op;
  assign stall   = rst_n && (luh || lrh || lwh || lsh);
  assign accept  = id_valid && id_lo_op && !stall;

  assign cnt_loaduse = cnt_lu_q;
  assign cnt_lostall = cnt_ls_q;

  // A new op accepted in the lo_done cycle reloads the unit without a gap.
  always_comb begin
    lo_busy_d = lo_busy_q;
    lo_cnt_d  = lo_cnt_q;
    lo_rd_d   = lo_rd_q;
    if (accept) begin
      lo_busy_d = 1'b1;
      lo_cnt_d  = LO_LAT_C;
      lo_rd_d   = id_regwrite ? id_rd : '0;
    end else if (lo_busy_q) begin
      lo_cnt_d = lo_cnt_q - 4'd1;
      if (lo_done)
        lo_busy_d = 1'b0;
    end
  end

  always_comb begin
    cnt_lu_d = cnt_lu_q;
    cnt_ls_d = cnt_ls_q;
    if (luh && stall && (cnt_lu_q != '1))
      cnt_lu_d = cnt_lu_q + CNT_W'(1);
    if ((lrh || lwh || lsh) && !luh && (cnt_ls_q != '1))
      cnt_ls_d = cnt_ls_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_busy_q <= 1'b0;
      lo_cnt_q  <= '0;
      lo_rd_q   <= '0;
      cnt_lu_q  <= '0;
      cnt_ls_q  <= '0;
    end else begin
      lo_busy_q <= lo_busy_d;
      lo_cnt_q  <= lo_cnt_d;
      lo_rd_q   <= lo_rd_d;
      cnt_lu_q  <= cnt_lu_d;
      cnt_ls_q  <= cnt_ls_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: vector table, directed long-op/reset
// sequences, and randomized traffic against a cycle-indexed reference model.
module tb_hazard_fwd_unit;
  localparam int NS  = 2;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 32;
  localparam longint unsigned MAXA = (64'd1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             id_valid, id_regwrite, id_lo_op, id_ex_memread;
  logic [NS*AW-1:0] id_rs, id_ex_rs;
  logic [NS-1:0]    id_rs_used;
  logic [AW-1:0]    id_rd, id_ex_rd, ex_mem_reg_rd, mem_wb_reg_rd;
  logic             ex_mem_regwrite, mem_wb_regwrite;

  logic [2*NS-1:0]  forward_sel, fs_b;
  logic             stall, lo_done, lo_busy, stall_b, lo_done_b, lo_busy_b;
  logic [CW-1:0]    cnt_loaduse, cnt_lostall;
  logic [3:0]       cnt_lu_b, cnt_ls_b;

  hazard_fwd_unit #(.NUM_SRC(NS), .REG_AW(AW), .LO_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_lo_op(id_lo_op), .id_ex_rs(id_ex_rs),
    .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .ex_mem_regwrite(ex_mem_regwrite),
    .ex_mem_reg_rd(ex_mem_reg_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_reg_rd(mem_wb_reg_rd), .forward_sel(forward_sel), .stall(stall),
    .lo_done(lo_done), .lo_busy(lo_busy), .cnt_loaduse(cnt_loaduse), .cnt_lostall(cnt_lostall));

  hazard_fwd_unit #(.NUM_SRC(NS), .REG_AW(AW), .LO_LAT(LAT), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_lo_op(id_lo_op), .id_ex_rs(id_ex_rs),
    .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread), .ex_mem_regwrite(ex_mem_regwrite),
    .ex_mem_reg_rd(ex_mem_reg_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_reg_rd(mem_wb_reg_rd), .forward_sel(fs_b), .stall(stall_b),
    .lo_done(lo_done_b), .lo_busy(lo_busy_b), .cnt_loaduse(cnt_lu_b), .cnt_lostall(cnt_ls_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the long op is described by the cycle in which it completes.
  int               cyc = 0;
  bit               m_act = 0;
  int               m_done_cyc = 0;
  logic [AW-1:0]    m_rd = '0;
  longint unsigned  m_lu = 0, m_ls = 0;
  logic [2*NS-1:0]  e_fs;
  bit               e_st, e_luh, e_lo, e_done, e_busy;

  function automatic longint unsigned sat4(input longint unsigned v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_eval();
    logic [AW-1:0] rs, xrs;
    bit match, lrh, lwh, lsh;
    e_busy = m_act && (cyc <= m_done_cyc);
    e_done = e_busy && (cyc == m_done_cyc);
    e_luh = 0; lrh = 0; e_fs = '0;
    for (int i = 0; i < NS; i++) begin
      rs  = id_rs[i*AW +: AW];
      xrs = id_ex_rs[i*AW +: AW];
      match = id_valid && id_rs_used[i] && (rs != 0);
      if (match && id_ex_memread && id_ex_rd != 0 && rs == id_ex_rd) e_luh = 1;
      if (match && e_busy && m_rd != 0 && rs == m_rd) lrh = 1;
      if (ex_mem_regwrite && ex_mem_reg_rd != 0 && ex_mem_reg_rd == xrs) e_fs[2*i +: 2] = 2'd2;
      else if (mem_wb_regwrite && mem_wb_reg_rd != 0 && mem_wb_reg_rd == xrs) e_fs[2*i +: 2] = 2'd1;
    end
    lwh  = e_busy && id_valid && id_regwrite && id_rd != 0 && id_rd == m_rd;
    lsh  = e_busy && !e_done && id_valid && id_lo_op;
    e_lo = lrh || lwh || lsh;
    e_st = e_luh || e_lo;
  endtask

  task automatic model_update();
    if (id_valid && id_lo_op && !e_st) begin
      m_act = 1;
      m_done_cyc = cyc + LAT;
      m_rd = id_regwrite ? id_rd : '0;
    end
    if (e_luh && e_st && m_lu < MAXA) m_lu++;
    if (e_lo && !e_luh && m_ls < MAXA) m_ls++;
    cyc++;
  endtask

  task automatic step(input string tag);
    model_eval();
    @(negedge clk);
    chk({tag, ".fs"}, forward_sel, e_fs);
    chk({tag, ".stall"}, stall, e_st);
    chk({tag, ".lo_done"}, lo_done, e_done);
    chk({tag, ".lo_busy"}, lo_busy, e_busy);
    chk({tag, ".cnt_lu"}, cnt_loaduse, m_lu);
    chk({tag, ".cnt_ls"}, cnt_lostall, m_ls);
    chk({tag, ".stall4"}, stall_b, e_st);
    chk({tag, ".done4"}, lo_done_b, e_done);
    chk({tag, ".busy4"}, lo_busy_b, e_busy);
    chk({tag, ".fs4"}, fs_b, e_fs);
    chk({tag, ".cnt_lu4"}, cnt_lu_b, sat4(m_lu));
    chk({tag, ".cnt_ls4"}, cnt_ls_b, sat4(m_ls));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0; id_regwrite = 0; id_lo_op = 0;
    id_ex_rs = '0; id_ex_rd = '0; id_ex_memread = 0; ex_mem_regwrite = 0; ex_mem_reg_rd = '0;
    mem_wb_regwrite = 0; mem_wb_reg_rd = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    m_act = 0; m_lu = 0; m_ls = 0;
    #1;
    chk("rst.stall", stall, 0);
    chk("rst.lo_done", lo_done, 0);
    chk("rst.lo_busy", lo_busy, 0);
    chk("rst.fs", forward_sel, 0);
    chk("rst.cnt_lu", cnt_loaduse, 0);
    chk("rst.cnt_ls", cnt_lostall, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct {
    logic vld; logic [9:0] rs; logic [1:0] used; logic [9:0] ex_rs;
    logic em_we; logic [4:0] em_rd; logic wb_we; logic [4:0] wb_rd;
    logic mrd; logic [4:0] ex_rd; logic [3:0] x_fs; logic x_st;
  } vec_t;
  vec_t tbl [9];

  initial begin
    // rs / ex_rs fields are {slot1, slot0}
    tbl[0] = '{1'b0, 10'd0, 2'b00, {5'd0, 5'd1}, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 5'd0, 4'b0010, 1'b0};
    tbl[1] = '{1'b0, 10'd0, 2'b00, {5'd0, 5'd0}, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 4'b0000, 1'b0};
    tbl[2] = '{1'b0, 10'd0, 2'b00, {5'd3, 5'd0}, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 4'b0100, 1'b0};
    tbl[3] = '{1'b0, 10'd0, 2'b00, {5'd2, 5'd2}, 1'b0, 5'd2, 1'b1, 5'd2, 1'b0, 5'd0, 4'b0101, 1'b0};
    tbl[4] = '{1'b0, 10'd0, 2'b00, {5'd4, 5'd4}, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 4'b1010, 1'b0};
    tbl[5] = '{1'b1, {5'd5, 5'd0}, 2'b11, 10'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 4'b0000, 1'b1};
    tbl[6] = '{1'b1, {5'd5, 5'd0}, 2'b01, 10'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 4'b0000, 1'b0};
    tbl[7] = '{1'b0, {5'd5, 5'd0}, 2'b11, 10'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 4'b0000, 1'b0};
    tbl[8] = '{1'b1, {5'd0, 5'd0}, 2'b11, 10'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 4'b0000, 1'b0};

    do_reset();
    for (int k = 0; k < 9; k++) begin
      id_valid = tbl[k].vld; id_rs = tbl[k].rs; id_rs_used = tbl[k].used; id_ex_rs = tbl[k].ex_rs;
      ex_mem_regwrite = tbl[k].em_we; ex_mem_reg_rd = tbl[k].em_rd;
      mem_wb_regwrite = tbl[k].wb_we; mem_wb_reg_rd = tbl[k].wb_rd;
      id_ex_memread = tbl[k].mrd; id_ex_rd = tbl[k].ex_rd;
      #2;
      chk($sformatf("tbl%0d.fs", k), forward_sel, tbl[k].x_fs);
      chk($sformatf("tbl%0d.stall", k), stall, tbl[k].x_st);
      step("tbl");
    end

    // load-use on slot 1, then the same with slot 1 not read
    do_reset();
    id_ex_memread = 1; id_ex_rd = 5; id_valid = 1; id_rs = {5'd5, 5'd0}; id_rs_used = 2'b10;
    #2 chk("lu.stall", stall, 1);
    step("lu");
    id_ex_memread = 0;
    #2 chk("lu.release", stall, 0);
    chk("lu.cnt", cnt_loaduse, 1);
    step("lu2");
    id_ex_memread = 1; id_rs_used = 2'b01;
    #2 chk("lu.unused", stall, 0);
    step("lu3");

    // long op to x7, reader of x7 waits through the lo_done cycle
    clear_inputs();
    id_valid = 1; id_lo_op = 1; id_regwrite = 1; id_rd = 7;
    #2 chk("lo.accept_stall", stall, 0);
    step("lo0");
    id_lo_op = 0; id_regwrite = 0; id_rd = 0; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      #2;
      chk($sformatf("raw%0d.stall", k), stall, 1);
      chk($sformatf("raw%0d.done", k), lo_done, k == 4);
      chk($sformatf("raw%0d.busy", k), lo_busy, 1);
      step("raw");
    end
    #2;
    chk("raw5.stall", stall, 0);
    chk("raw5.busy", lo_busy, 0);
    chk("raw5.cnt_ls", cnt_lostall, 4);
    step("raw5");

    // back-to-back long ops: second waits for the lo_done cycle
    clear_inputs();
    id_valid = 1; id_lo_op = 1; id_regwrite = 1; id_rd = 8;
    step("b2b0");
    id_rd = 9;
    for (int k = 1; k <= 4; k++) begin
      #2;
      chk($sformatf("b2b%0d.stall", k), stall, k != 4);
      chk($sformatf("b2b%0d.done", k), lo_done, k == 4);
      step("b2b");
    end
    clear_inputs();
    for (int k = 5; k <= 8; k++) begin
      #2;
      chk($sformatf("b2b%0d.busy", k), lo_busy, 1);
      chk($sformatf("b2b%0d.done", k), lo_done, k == 8);
      step("b2b");
    end
    #2;
    chk("b2b9.busy", lo_busy, 0);
    chk("b2b9.cnt_ls", cnt_lostall, 7);
    step("b2b9");

    // reset in the middle of a long op
    id_valid = 1; id_lo_op = 1; id_regwrite = 1; id_rd = 6;
    step("mid0");
    clear_inputs();
    step("mid1");
    step("mid2");
    #1 chk("mid.busy_before", lo_busy, 1);
    rst_n = 0;
    #1;
    chk("mid.busy", lo_busy, 0);
    chk("mid.done", lo_done, 0);
    chk("mid.cnt_lu", cnt_loaduse, 0);
    chk("mid.cnt_ls", cnt_lostall, 0);
    m_act = 0; m_lu = 0; m_ls = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      #2 chk($sformatf("mid_post%0d.done", k), lo_done, 0);
      step("mid_post");
    end

    // randomized traffic on a small register window to provoke hazards
    for (int k = 0; k < 600; k++) begin
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs           = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_used      = 2'($urandom_range(0, 3));
      id_rd           = 5'($urandom_range(0, 3));
      id_regwrite     = 1'($urandom_range(0, 1));
      id_lo_op        = ($urandom_range(0, 3) == 0);
      id_ex_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_ex_rd        = 5'($urandom_range(0, 3));
      id_ex_memread   = ($urandom_range(0, 3) == 0);
      ex_mem_regwrite = 1'($urandom_range(0, 1));
      ex_mem_reg_rd   = 5'($urandom_range(0, 3));
      mem_wb_regwrite = 1'($urandom_range(0, 1));
      mem_wb_reg_rd   = 5'($urandom_range(0, 3));
      step("rnd");
    end

    // saturation of the 4-bit counters under sustained stall
    do_reset();
    id_ex_memread = 1; id_ex_rd = 5; id_valid = 1; id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01;
    for (int k = 0; k < 20; k++) step("sat_lu");
    chk("sat.cnt_lu4", cnt_lu_b, 4'hF);
    chk("sat.cnt_lu32", cnt_loaduse, 20);
    clear_inputs();
    id_valid = 1; id_lo_op = 1;
    for (int k = 0; k < 40; k++) step("sat_ls");
    chk("sat.cnt_ls4", cnt_ls_b, 4'hF);
    chk("sat.cnt_lu4_hold", cnt_lu_b, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
